orao_vram_arbiter: RTL and testbench

//  Shares one single-port synchronous 8 KB video RAM (1-cycle read latency) between the

---
 rtl/orao_vram_arbiter_if.sv | 28 ++
 rtl/orao_vram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_orao_vram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/orao_vram_arbiter_if.sv
// Requester-side bus of the Orao video RAM arbiter: display fetch port and CPU port.
// master = requesters (display generator / CPU), slave = arbiter.
interface orao_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 13
) ();
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [7:0]        disp_data;
    logic              disp_valid;
    logic              disp_overrun;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  disp_data, disp_valid, disp_overrun, cpu_rdata, cpu_ack
    );

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output disp_data, disp_valid, disp_overrun, cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/orao_vram_arbiter.sv
// Shares one single-port synchronous video RAM between display fetch and CPU, one access per
// pixel clock; display has priority, CPU gets a forced slot after CPU_MAX_WAIT lost cycles.
module orao_vram_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 4,
    parameter int unsigned ADDR_W       = 13
) (
    input  logic               clk_pixel,
    input  logic               reset,
    orao_vram_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata
);

    localparam logic [1:0] GntIdle = 2'd0;
    localparam logic [1:0] GntDisp = 2'd1;
    localparam logic [1:0] GntCpu  = 2'd2;
    localparam logic [3:0] MaxWait = 4'(CPU_MAX_WAIT);

    logic              disp_pend_q, disp_pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              disp_overrun_q, disp_overrun_d;
    logic              cpu_inflight_q, cpu_inflight_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    // g1: access presented to the RAM this cycle; g2: read data arriving from the RAM.
    logic              g1_disp_q, g1_disp_d;
    logic              g1_rd_q, g1_rd_d;
    logic              g1_wr_q, g1_wr_d;
    logic              g2_disp_q, g2_disp_d;
    logic              g2_rd_q, g2_rd_d;

    logic              disp_valid_q, disp_valid_d;
    logic [7:0]        disp_data_q, disp_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;

    logic              cpu_ok;
    logic              cpu_force;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] gnt_addr;

    always_comb begin
        cpu_ok         = bus.cpu_req & ~cpu_inflight_q;
        cpu_force      = cpu_ok & (wait_cnt_q == MaxWait);
        gnt            = GntIdle;
        gnt_addr       = ram_addr_q;
        disp_pend_d    = disp_pend_q;
        pend_addr_d    = pend_addr_q;
        disp_overrun_d = disp_overrun_q;

        if (cpu_force) begin
            gnt      = GntCpu;
            gnt_addr = bus.cpu_addr;
            // The losing display request is parked; a second one has nowhere to go.
            if (bus.disp_req) begin
                if (disp_pend_q) begin
                    disp_overrun_d = 1'b1;
                end else begin
                    disp_pend_d = 1'b1;
                    pend_addr_d = bus.disp_addr;
                end
            end
        end else if (disp_pend_q) begin
            gnt         = GntDisp;
            gnt_addr    = pend_addr_q;
            disp_pend_d = bus.disp_req;
            if (bus.disp_req) begin
                pend_addr_d = bus.disp_addr;
            end
        end else if (bus.disp_req) begin
            gnt      = GntDisp;
            gnt_addr = bus.disp_addr;
        end else if (cpu_ok) begin
            gnt      = GntCpu;
            gnt_addr = bus.cpu_addr;
        end
    end

    always_comb begin
        ram_addr_d  = gnt_addr;
        ram_we_d    = (gnt == GntCpu) & bus.cpu_we;
        ram_wdata_d = (gnt == GntCpu) ? bus.cpu_wdata : ram_wdata_q;

        g1_disp_d = (gnt == GntDisp);
        g1_rd_d   = (gnt == GntCpu) & ~bus.cpu_we;
        g1_wr_d   = (gnt == GntCpu) & bus.cpu_we;
        g2_disp_d = g1_disp_q;
        g2_rd_d   = g1_rd_q;

        disp_valid_d = g2_disp_q;
        disp_data_d  = g2_disp_q ? ram_rdata : disp_data_q;
        // Writes complete once the RAM has sampled them; reads once data is captured.
        cpu_ack_d    = g1_wr_q | g2_rd_q;
        cpu_rdata_d  = g2_rd_q ? ram_rdata : cpu_rdata_q;

        if (gnt == GntCpu) begin
            cpu_inflight_d = 1'b1;
        end else if (cpu_ack_d) begin
            cpu_inflight_d = 1'b0;
        end else begin
            cpu_inflight_d = cpu_inflight_q;
        end

        if ((gnt == GntCpu) || !bus.cpu_req) begin
            wait_cnt_d = 4'd0;
        end else if (cpu_ok && (wait_cnt_q != MaxWait)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            disp_pend_q    <= 1'b0;
            pend_addr_q    <= '0;
            disp_overrun_q <= 1'b0;
            cpu_inflight_q <= 1'b0;
            wait_cnt_q     <= 4'd0;
            ram_addr_q     <= '0;
            ram_we_q       <= 1'b0;
            ram_wdata_q    <= 8'h00;
            g1_disp_q      <= 1'b0;
            g1_rd_q        <= 1'b0;
            g1_wr_q        <= 1'b0;
            g2_disp_q      <= 1'b0;
            g2_rd_q        <= 1'b0;
            disp_valid_q   <= 1'b0;
            disp_data_q    <= 8'h00;
            cpu_ack_q      <= 1'b0;
            cpu_rdata_q    <= 8'h00;
        end else begin
            disp_pend_q    <= disp_pend_d;
            pend_addr_q    <= pend_addr_d;
            disp_overrun_q <= disp_overrun_d;
            cpu_inflight_q <= cpu_inflight_d;
            wait_cnt_q     <= wait_cnt_d;
            ram_addr_q     <= ram_addr_d;
            ram_we_q       <= ram_we_d;
            ram_wdata_q    <= ram_wdata_d;
            g1_disp_q      <= g1_disp_d;
            g1_rd_q        <= g1_rd_d;
            g1_wr_q        <= g1_wr_d;
            g2_disp_q      <= g2_disp_d;
            g2_rd_q        <= g2_rd_d;
            disp_valid_q   <= disp_valid_d;
            disp_data_q    <= disp_data_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_rdata_q    <= cpu_rdata_d;
        end
    end

    assign ram_addr         = ram_addr_q;
    assign ram_we           = ram_we_q;
    assign ram_wdata        = ram_wdata_q;
    assign bus.disp_data    = disp_data_q;
    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_overrun = disp_overrun_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_ack      = cpu_ack_q;

endmodule

// File: tb/tb_orao_vram_arbiter.sv
// Directed bench for orao_vram_arbiter with a synchronous 8 KB RAM model and a display
// expectation queue; all expected values are hand-derived constants or bench-written data.
module tb_orao_vram_arbiter;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    orao_vram_arbiter_if #(.ADDR_W(13)) bus ();

    orao_vram_arbiter #(
        .CPU_MAX_WAIT(4),
        .ADDR_W      (13)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'((a * 7) + 3);
        if (a == 32'h123) v = 8'hA5;
        return v;
    endfunction

    // RAM model: content set up on the first edge, then 1-cycle synchronous read.
    logic [7:0] mem [0:8191];
    bit         mem_ready = 1'b0;
    always @(posedge clk_pixel) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    logic [7:0] ref_mem [0:8191];
    int         cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    wire [40:0] all_outs = {bus.disp_data, bus.disp_valid, bus.disp_overrun, bus.cpu_rdata,
                            bus.cpu_ack, ram_addr, ram_we, ram_wdata};

    logic [7:0]  exp_q [$];
    int          cyc_q [$];
    int          lat_log [$];
    bit          mon_en = 1'b1;
    int          disp_cnt = 0;
    int          we_cnt = 0;
    logic [12:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;
    int          mon_lat;
    logic [7:0]  mon_d;
    int          mon_c;

    always @(negedge clk_pixel) begin
        if (ram_we) begin
            we_cnt++;
            last_we_addr = ram_addr;
            last_we_data = ram_wdata;
        end
        if (bus.disp_valid) begin
            disp_cnt++;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("disp_spurious", 64'(bus.disp_valid), 64'(0));
                end else begin
                    mon_d   = exp_q.pop_front();
                    mon_c   = cyc_q.pop_front();
                    mon_lat = cyc - mon_c;
                    lat_log.push_back(mon_lat);
                    check("disp_data", 64'(bus.disp_data), 64'(mon_d));
                    check("disp_lat", 64'((mon_lat == 3) || (mon_lat == 4)), 64'(1));
                end
            end
        end
    end

    task automatic disp_drive(input logic [12:0] addr);
        bus.disp_req  = 1'b1;
        bus.disp_addr = addr;
        exp_q.push_back(ref_mem[addr]);
        cyc_q.push_back(cyc);
    endtask

    task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
        int start;
        bit done;
        start = cyc;
        done  = 1'b0;
        rd    = 8'h00;
        lat   = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk_pixel);
            if (bus.cpu_ack) begin
                done = 1'b1;
                rd   = bus.cpu_rdata;
                lat  = cyc - start;
            end
        end
        bus.cpu_req = 1'b0;
        if (!done) check("cpu_timeout", 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] rd;
    int         lat, base, we0, we_at, ack_at;
    bit         seen_ack, seen_valid, t6_done;
    logic       ov10, ov11;

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // T1a: outputs held at zero under reset
        repeat (3) @(negedge clk_pixel);
        check("t1_reset_outs", 64'(all_outs), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk_pixel);

        // T2: single display read of 0x0123
        disp_drive(13'h0123);
        @(negedge clk_pixel);
        bus.disp_req = 1'b0;
        check("t2_ram_addr", 64'(ram_addr), 64'(13'h0123));
        check("t2_ram_we", 64'(ram_we), 64'(0));
        @(negedge clk_pixel);
        check("t2_valid_early", 64'(bus.disp_valid), 64'(0));
        @(negedge clk_pixel);
        check("t2_valid", 64'({bus.disp_valid, bus.disp_data}), 64'({1'b1, 8'hA5}));
        @(negedge clk_pixel);
        check("t2_valid_hold", 64'({bus.disp_valid, bus.disp_data}), 64'({1'b0, 8'hA5}));

        // T3: CPU write then read back at the top address
        we0 = we_cnt;
        cpu_op(1'b1, 13'h1FFF, 8'h3C, rd, lat);
        ref_mem[13'h1FFF] = 8'h3C;
        check("t3_wr_lat", 64'(lat), 64'(2));
        check("t3_we_pulses", 64'(we_cnt - we0), 64'(1));
        check("t3_we_addr", 64'(last_we_addr), 64'(13'h1FFF));
        check("t3_we_data", 64'(last_we_data), 64'(8'h3C));
        @(negedge clk_pixel);
        cpu_op(1'b0, 13'h1FFF, 8'h00, rd, lat);
        check("t3_rd_lat", 64'(lat), 64'(3));
        check("t3_rdata", 64'(rd), 64'(8'h3C));
        @(negedge clk_pixel);
        check("t3_rdata_hold", 64'({bus.cpu_ack, bus.cpu_rdata}), 64'({1'b0, 8'h3C}));

        // T1b: reset one cycle after a CPU read grant drops the access
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
        @(negedge clk_pixel);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        check("t1_mid_reset_outs", 64'(all_outs), 64'(0));
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        seen_ack = 1'b0; seen_valid = 1'b0;
        repeat (6) begin
            @(negedge clk_pixel);
            seen_ack   |= bus.cpu_ack;
            seen_valid |= bus.disp_valid;
        end
        check("t1_no_ack", 64'(seen_ack), 64'(0));
        check("t1_no_valid", 64'(seen_valid), 64'(0));

        // T4: display every cycle with CPU write held -> forced grant on the 5th edge
        lat_log.delete();
        base = disp_cnt;
        we_at = -1; ack_at = -1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1000; bus.cpu_wdata = 8'h77;
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) disp_drive(13'(16 + i - 1));
            else bus.disp_req = 1'b0;
            @(negedge clk_pixel);
            if (ram_we && we_at < 0) we_at = i;
            if (bus.cpu_ack) begin
                ack_at = i;
                bus.cpu_req = 1'b0;
            end
        end
        ref_mem[13'h1000] = 8'h77;
        repeat (4) @(negedge clk_pixel);
        check("t4_cpu_grant_edge", 64'(we_at), 64'(5));
        check("t4_cpu_ack_edge", 64'(ack_at), 64'(6));
        check("t4_we_addr", 64'(last_we_addr), 64'(13'h1000));
        check("t4_disp_count", 64'(disp_cnt - base), 64'(8));
        check("t4_overrun", 64'(bus.disp_overrun), 64'(0));
        check("t4_lat_count", 64'(lat_log.size()), 64'(8));
        if (lat_log.size() == 8) begin
            check("t4_lat_before_force", 64'(lat_log[3]), 64'(3));
            check("t4_lat_displaced", 64'(lat_log[4]), 64'(4));
        end

        // T5: two forced CPU grants against a continuous display stream -> one fetch lost
        mon_en = 1'b0;
        base = disp_cnt;
        ov10 = 1'b0; ov11 = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1800; bus.cpu_wdata = 8'h99;
        for (int i = 1; i <= 16; i++) begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = 13'(32 + i);
            @(negedge clk_pixel);
            if (i == 10) ov10 = bus.disp_overrun;
            if (i == 11) ov11 = bus.disp_overrun;
        end
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        ref_mem[13'h1800] = 8'h99;
        repeat (6) @(negedge clk_pixel);
        check("t5_no_overrun_yet", 64'(ov10), 64'(0));
        check("t5_overrun_set", 64'(ov11), 64'(1));
        check("t5_disp_count", 64'(disp_cnt - base), 64'(15));
        repeat (10) @(negedge clk_pixel);
        check("t5_overrun_sticky", 64'(bus.disp_overrun), 64'(1));
        mon_en = 1'b1;
        reset = 1'b1;
        @(negedge clk_pixel);
        check("t5_reset_clears", 64'(all_outs), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk_pixel);

        // T6: 32 display fetches every 8 cycles while the CPU hammers the upper half
        t6_done = 1'b0;
        base = disp_cnt;
        fork
            begin
                for (int b = 0; b < 32; b++) begin
                    disp_drive(13'($urandom_range(0, 4095)));
                    @(negedge clk_pixel);
                    bus.disp_req = 1'b0;
                    repeat (7) @(negedge clk_pixel);
                end
                t6_done = 1'b1;
            end
            begin
                logic [12:0] a;
                logic [7:0]  d;
                logic [7:0]  r;
                int          l;
                bit          w;
                while (!t6_done) begin
                    a = 13'($urandom_range(4096, 8191));
                    d = 8'($urandom);
                    w = 1'($urandom);
                    cpu_op(w, a, d, r, l);
                    if (w) ref_mem[a] = d;
                    else check("t6_cpu_rdata", 64'(r), 64'(ref_mem[a]));
                    check("t6_cpu_lat", 64'(l <= 7), 64'(1));
                    @(negedge clk_pixel);
                end
            end
        join
        repeat (8) @(negedge clk_pixel);
        check("t6_disp_count", 64'(disp_cnt - base), 64'(32));
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t6_overrun", 64'(bus.disp_overrun), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
